// File: rtl/apb4_regfile_gen.sv
// APB4 register file: RW config registers, RO status registers, W1C interrupt
// status with enable mask, and a write-only command pulse register.
module apb4_regfile_gen #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_RW   = 4,
    parameter int unsigned N_RO   = 2,
    parameter int unsigned N_IRQ  = 8,
    parameter logic [N_RW*DATA_W-1:0] RW_RST = '0
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [DATA_W-1:0]        pwdata,
    input  logic [DATA_W/8-1:0]      pstrb,
    output logic [DATA_W-1:0]        prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [N_RW*DATA_W-1:0]   cfg_rw,
    input  logic [N_RO*DATA_W-1:0]   sts_ro,
    input  logic [N_IRQ-1:0]         irq_set,
    output logic                     irq,
    output logic [DATA_W-1:0]        cmd_pulse
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PAGE_W = ADDR_W - 8;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] rw_q [N_RW];
    logic [N_IRQ-1:0]  ist_q;
    logic [N_IRQ-1:0]  ien_q;
    logic              irq_q;
    logic [DATA_W-1:0] cmd_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [PAGE_W-1:0] page;
    logic [5:0]        idx;
    logic              hit_rw, hit_ro, hit_sys, hit_ist, hit_ien, hit_cmd;
    logic              misalign, err_c;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] wmask, wdata_m;
    logic              cap, wr_en, ready_c;
    logic              wr_rw, wr_ist, wr_ien, wr_cmd;
    logic [N_IRQ-1:0]  ist_clr;

    // Address decode: 256-byte pages select RW / RO / system registers
    assign page     = paddr[ADDR_W-1:8];
    assign idx      = paddr[7:2];
    assign hit_rw   = (page == '0) && (7'(idx) < 7'(N_RW));
    assign hit_ro   = (page == PAGE_W'(1)) && (7'(idx) < 7'(N_RO));
    assign hit_sys  = (page == PAGE_W'(2));
    assign hit_ist  = hit_sys && (idx == 6'd0);
    assign hit_ien  = hit_sys && (idx == 6'd1);
    assign hit_cmd  = hit_sys && (idx == 6'd2);
    assign misalign = (DATA_W == 32) && (paddr[1:0] != 2'b00);
    assign err_c    = misalign || !(hit_rw || hit_ro || hit_ist || hit_ien || hit_cmd)
                      || (pwrite && hit_ro);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < int'(N_RW); i++) begin
            if (hit_rw && (idx == 6'(i))) rd_mux = rw_q[i];
        end
        for (int j = 0; j < int'(N_RO); j++) begin
            if (hit_ro && (idx == 6'(j))) rd_mux = sts_ro[j*DATA_W +: DATA_W];
        end
        if (hit_ist) rd_mux = DATA_W'(ist_q);
        if (hit_ien) rd_mux = DATA_W'(ien_q);
    end

    always_comb begin
        wmask = '0;
        for (int b = 0; b < int'(STRB_W); b++) begin
            wmask[b*8 +: 8] = {8{pstrb[b]}};
        end
    end
    assign wdata_m = pwdata & wmask;

    // Transfer phase: first access cycle captures read data, second completes
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        wr_en   = 1'b0;
        ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (psel && penable) begin
                    state_d = ST_ACCESS;
                    cap     = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (psel && penable) begin
                    ready_c = 1'b1;
                    wr_en   = pwrite && !err_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pready  = ready_c;
    assign pslverr = ready_c && err_q;
    assign prdata  = ready_c ? rdata_q : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (cap) begin
            err_q   <= err_c;
            rdata_q <= (err_c || pwrite) ? '0 : rd_mux;
        end
    end

    assign wr_rw   = wr_en && hit_rw;
    assign wr_ist  = wr_en && hit_ist;
    assign wr_ien  = wr_en && hit_ien;
    assign wr_cmd  = wr_en && hit_cmd;
    assign ist_clr = wr_ist ? wdata_m[N_IRQ-1:0] : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(N_RW); i++) rw_q[i] <= RW_RST[i*DATA_W +: DATA_W];
        end else begin
            for (int i = 0; i < int'(N_RW); i++) begin
                if (wr_rw && (idx == 6'(i))) rw_q[i] <= (rw_q[i] & ~wmask) | wdata_m;
            end
        end
    end

    // Hardware set takes priority over a software clear of the same bit
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ist_q <= '0;
            ien_q <= '0;
            irq_q <= 1'b0;
            cmd_q <= '0;
        end else begin
            ist_q <= (ist_q & ~ist_clr) | irq_set;
            if (wr_ien) ien_q <= (ien_q & ~wmask[N_IRQ-1:0]) | wdata_m[N_IRQ-1:0];
            irq_q <= |(ist_q & ien_q);
            cmd_q <= wr_cmd ? wdata_m : '0;
        end
    end

    assign irq       = irq_q;
    assign cmd_pulse = cmd_q;

    for (genvar i = 0; i < int'(N_RW); i++) begin : g_cfg
        assign cfg_rw[i*DATA_W +: DATA_W] = rw_q[i];
    end

endmodule

// File: tb/tb_apb4_regfile_gen.sv
// Bench for apb4_regfile_gen: directed vector table, corner sequences and
// randomized transfers checked against a register-map reference model.
module tb_apb4_regfile_gen;

    localparam int unsigned NRW = 4;
    localparam int unsigned NRO = 2;
    localparam logic [NRW*32-1:0] RST_V = {32'h0F0F_F0F0, 32'hCAFE_0002, 32'h0000_0000, 32'h0001_0001};
    localparam logic [NRO*32-1:0] STS_V = {32'h0000_BEEF, 32'h5A5A_0001};

    logic              clk, rst_b;
    logic [11:0]       paddr;
    logic              psel, penable, pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       prdata;
    logic              pready, pslverr;
    logic [NRW*32-1:0] cfg_rw;
    logic [NRO*32-1:0] sts_ro;
    logic [7:0]        irq_set;
    logic              irq;
    logic [31:0]       cmd_pulse;

    int errors = 0;
    int checks = 0;
    logic [31:0] cmd_exp;
    bit          mon_en;

    logic [31:0] rw_m [NRW];
    logic [31:0] sts_m [NRO];
    logic [7:0]  ist_m, ien_m;

    apb4_regfile_gen #(
        .ADDR_W(12), .DATA_W(32), .N_RW(NRW), .N_RO(NRO), .N_IRQ(8), .RW_RST(RST_V)
    ) dut (
        .clk(clk), .rst_b(rst_b), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .cfg_rw(cfg_rw), .sts_ro(sts_ro),
        .irq_set(irq_set), .irq(irq), .cmd_pulse(cmd_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // cmd_pulse must equal the expected strobe data exactly one cycle after a CMD write
    always @(negedge clk) begin
        if (mon_en) begin
            check("cmd_pulse", 128'(cmd_pulse), 128'(cmd_exp));
            cmd_exp = '0;
        end
    end

    function automatic logic [31:0] smask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NRW); i++) rw_m[i] = RST_V[i*32 +: 32];
        for (int j = 0; j < int'(NRO); j++) sts_m[j] = STS_V[j*32 +: 32];
        ist_m = '0;
        ien_m = '0;
    endtask

    // Register-map semantics: returns expected error and read data, applies writes
    task automatic model_access(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                                input logic [3:0] st, output bit er, output logic [31:0] rd);
        int unsigned ai;
        logic [31:0] m;
        int k;
        ai = 32'(a);
        m  = smask(st);
        er = 1'b0;
        rd = '0;
        if (ai % 4 != 0) er = 1'b1;
        else if (ai < 4 * NRW) begin
            k = int'(ai / 4);
            if (wr) rw_m[k] = (rw_m[k] & ~m) | (wd & m);
            else rd = rw_m[k];
        end else if (ai >= 256 && ai < 256 + 4 * NRO) begin
            k = int'((ai - 256) / 4);
            if (wr) er = 1'b1;
            else rd = sts_m[k];
        end else if (ai == 512) begin
            if (wr) ist_m = ist_m & ~(wd[7:0] & m[7:0]);
            else rd = {24'h0, ist_m};
        end else if (ai == 516) begin
            if (wr) ien_m = (ien_m & ~m[7:0]) | (wd[7:0] & m[7:0]);
            else rd = {24'h0, ien_m};
        end else if (ai == 520) begin
            rd = '0;
        end else er = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One APB transfer; returns when the completing edge has passed
    task automatic xfer(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output bit er);
        int n;
        bit got;
        rd = '0;
        er = 1'b0;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pstrb = st;
        @(posedge clk);
        #1 penable = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            if (pready === 1'b1) begin
                got = 1'b1;
                rd  = prdata;
                er  = pslverr;
            end else begin
                n++;
                @(posedge clk);
                #1;
            end
        end
        check($sformatf("wait_states@%h", a), 128'(n), 128'd1);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        cmd_exp = (got && wr && a == 12'h208) ? (wd & smask(st)) : '0;
    endtask

    typedef struct {
        logic [11:0] a;
        bit          wr;
        logic [31:0] wd;
        logic [3:0]  st;
        bit          eerr;
        logic [31:0] erd;
    } vec_t;

    vec_t vt [20];
    logic [11:0] alist [16];

    initial begin
        bit er, mer;
        logic [31:0] rd, mrd;
        logic [11:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        bit          wr;
        logic [7:0]  s;
        logic [127:0] flat;

        vt[0]  = '{12'h000, 1'b0, 32'h0,          4'h0, 1'b0, 32'h0001_0001};
        vt[1]  = '{12'h004, 1'b1, 32'hAABB_CCDD,  4'h5, 1'b0, 32'h0};
        vt[2]  = '{12'h004, 1'b0, 32'h0,          4'h0, 1'b0, 32'h00BB_00DD};
        vt[3]  = '{12'h100, 1'b1, 32'h1234_5678,  4'hF, 1'b1, 32'h0};
        vt[4]  = '{12'h3F0, 1'b0, 32'h0,          4'h0, 1'b1, 32'h0};
        vt[5]  = '{12'h002, 1'b0, 32'h0,          4'h0, 1'b1, 32'h0};
        vt[6]  = '{12'h100, 1'b0, 32'h0,          4'h0, 1'b0, 32'h5A5A_0001};
        vt[7]  = '{12'h104, 1'b0, 32'h0,          4'h0, 1'b0, 32'h0000_BEEF};
        vt[8]  = '{12'h108, 1'b0, 32'h0,          4'h0, 1'b1, 32'h0};
        vt[9]  = '{12'h010, 1'b0, 32'h0,          4'h0, 1'b1, 32'h0};
        vt[10] = '{12'h208, 1'b1, 32'h1234_5678,  4'h3, 1'b0, 32'h0};
        vt[11] = '{12'h208, 1'b0, 32'h0,          4'h0, 1'b0, 32'h0};
        vt[12] = '{12'h204, 1'b1, 32'hFFFF_FFFF,  4'hF, 1'b0, 32'h0};
        vt[13] = '{12'h204, 1'b0, 32'h0,          4'h0, 1'b0, 32'h0000_00FF};
        vt[14] = '{12'h20C, 1'b0, 32'h0,          4'h0, 1'b1, 32'h0};
        vt[15] = '{12'h004, 1'b1, 32'h1122_3344,  4'h0, 1'b0, 32'h0};
        vt[16] = '{12'h004, 1'b0, 32'h0,          4'h0, 1'b0, 32'h00BB_00DD};
        vt[17] = '{12'h008, 1'b0, 32'h0,          4'h0, 1'b0, 32'hCAFE_0002};
        vt[18] = '{12'h204, 1'b1, 32'h0,          4'hF, 1'b0, 32'h0};
        vt[19] = '{12'h00C, 1'b0, 32'h0,          4'h0, 1'b0, 32'h0F0F_F0F0};

        alist = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h100, 12'h104, 12'h108,
                  12'h200, 12'h204, 12'h208, 12'h20C, 12'h3F0, 12'h001, 12'h006, 12'h0FC};

        rst_b = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; irq_set = '0;
        sts_ro = STS_V; cmd_exp = '0; mon_en = 1'b0;
        model_reset();

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 128'(pready), 128'd0);
        check("rst_prdata", 128'(prdata), 128'd0);
        check("rst_pslverr", 128'(pslverr), 128'd0);
        check("rst_irq", 128'(irq), 128'd0);
        check("rst_cmd", 128'(cmd_pulse), 128'd0);
        check("rst_cfg", 128'(cfg_rw), 128'(RST_V));
        rst_b = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 20; i++) begin
            xfer(vt[i].a, vt[i].wr, vt[i].wd, vt[i].st, rd, er);
            model_access(vt[i].a, vt[i].wr, vt[i].wd, vt[i].st, mer, mrd);
            check($sformatf("vec%0d_err", i), 128'(er), 128'(vt[i].eerr));
            check($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vt[i].erd));
        end
        check("cfg_rw1_strobed", 128'(cfg_rw[63:32]), 128'h00BB_00DD);
        check("cfg_after_table", 128'(cfg_rw), {RST_V[127:64], 32'h00BB_00DD, RST_V[31:0]});

        // Interrupt set/clear priority and irq latency
        irq_set = 8'h08;
        idle(1);
        irq_set = 8'h00;
        ist_m = ist_m | 8'h08;
        idle(2);
        @(negedge clk);
        check("irq_masked", 128'(irq), 128'd0);
        xfer(12'h204, 1'b1, 32'h08, 4'hF, rd, er);
        model_access(12'h204, 1'b1, 32'h08, 4'hF, mer, mrd);
        idle(1);
        @(negedge clk);
        check("irq_enabled", 128'(irq), 128'd1);
        irq_set = 8'h08;
        xfer(12'h200, 1'b1, 32'h08, 4'hF, rd, er);
        irq_set = 8'h00;
        check("ist_clr_err", 128'(er), 128'd0);
        xfer(12'h200, 1'b0, 32'h0, 4'h0, rd, er);
        check("ist_set_wins", 128'(rd), 128'h08);
        xfer(12'h200, 1'b1, 32'h08, 4'hF, rd, er);
        model_access(12'h200, 1'b1, 32'h08, 4'hF, mer, mrd);
        @(negedge clk);
        check("irq_lag", 128'(irq), 128'd1);
        @(posedge clk);
        @(negedge clk);
        check("irq_cleared", 128'(irq), 128'd0);

        // CMD pulse lasts one cycle and reads back as zero
        xfer(12'h208, 1'b1, 32'h5, 4'hF, rd, er);
        @(negedge clk);
        check("cmd_pulse_hi", 128'(cmd_pulse), 128'h5);
        @(posedge clk);
        @(negedge clk);
        check("cmd_pulse_lo", 128'(cmd_pulse), 128'h0);
        xfer(12'h208, 1'b0, 32'h0, 4'h0, rd, er);
        check("cmd_read", 128'(rd), 128'h0);

        // psel dropped after the first access cycle: no write, no pulse
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; paddr = 12'h00C; pwrite = 1'b1; pwdata = 32'h9999_9999; pstrb = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_pready", 128'(pready), 128'd0);
        check("abort_pslverr", 128'(pslverr), 128'd0);
        idle(1);
        #1 psel = 1'b1; penable = 1'b0; paddr = 12'h208; pwrite = 1'b1; pwdata = 32'hF; pstrb = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        idle(2);
        xfer(12'h00C, 1'b0, 32'h0, 4'h0, rd, er);
        check("abort_no_write", 128'(rd), 128'(rw_m[3]));

        // Reset during the first access cycle of a write
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        check("rstmid_pready0", 128'(pready), 128'd0);
        rst_b = 1'b0;
        #1;
        check("rstmid_prdata", 128'(prdata), 128'd0);
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("rstmid_rw2", 128'(cfg_rw[95:64]), 128'hCAFE_0002);
        check("rstmid_cfg", 128'(cfg_rw), 128'(RST_V));
        xfer(12'h008, 1'b1, 32'h1357_2468, 4'hF, rd, er);
        model_access(12'h008, 1'b1, 32'h1357_2468, 4'hF, mer, mrd);
        check("post_rst_wr_err", 128'(er), 128'd0);
        xfer(12'h008, 1'b0, 32'h0, 4'h0, rd, er);
        check("post_rst_rd", 128'(rd), 128'h1357_2468);

        // Randomized transfers against the register-map model
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(3) == 0) begin
                s = 8'($urandom);
                irq_set = s;
                idle(1);
                irq_set = 8'h00;
                ist_m = ist_m | s;
            end
            a  = ($urandom_range(3) == 0) ? 12'($urandom) : alist[$urandom_range(15)];
            wr = 1'($urandom);
            wd = $urandom;
            st = 4'($urandom);
            model_access(a, wr, wd, st, mer, mrd);
            xfer(a, wr, wd, st, rd, er);
            check($sformatf("rnd%0d_err@%h", it, a), 128'(er), 128'(mer));
            check($sformatf("rnd%0d_rdata@%h", it, a), 128'(rd), 128'(mrd));
            if ($urandom_range(1) == 0) begin
                idle(1);
                @(negedge clk);
                check($sformatf("rnd%0d_irq", it), 128'(irq), 128'(|(ist_m & ien_m)));
            end
        end
        for (int i = 0; i < int'(NRW); i++) flat[i*32 +: 32] = rw_m[i];
        check("rnd_cfg_rw", 128'(cfg_rw), flat);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
